// File: rtl/lif_pkg.sv
// lif_pkg: shared types and saturating arithmetic for the LIF neuron array.
package lif_pkg;
  typedef enum logic {IDLE, SWEEP} state_t;
  function automatic int refrac_w(input int steps);
    return steps < 1 ? 1 : $clog2(steps + 1);
  endfunction
  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return x > hi ? hi : x < lo ? lo : x;
  endfunction
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a, input logic signed [63:0] b, input int w);
    return sat_narrow(a + b, w);
  endfunction
endpackage

// File: rtl/lif_update_core.sv
// lif_update_core: combinational leak/integrate/threshold/refractory update of one neuron.
module lif_update_core
  import lif_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter logic signed [DATA_W-1:0] V_REST = 0,
  parameter logic signed [DATA_W-1:0] V_TH = 1024,
  parameter logic signed [DATA_W-1:0] V_RESET = 0,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC_STEPS = 4,
  parameter int RW = refrac_w(REFRAC_STEPS)
) (
  input  logic signed [DATA_W-1:0] v,
  input  logic signed [DATA_W-1:0] i_acc,
  input  logic [RW-1:0]            refrac,
  output logic signed [DATA_W-1:0] v_nxt,
  output logic [RW-1:0]            refrac_nxt,
  output logic                     spike
);
  localparam int W2 = DATA_W + 2;
  logic signed [W2-1:0] d;
  logic signed [DATA_W-1:0] vs;
  logic stuck;
  always_comb begin
    d = (W2'(i_acc) - (W2'(v) - W2'(V_REST))) >>> LEAK_SHIFT;
    vs = DATA_W'(sat_narrow(64'(W2'(v) + d), DATA_W));
    stuck = refrac != '0;
    spike = !stuck && vs >= V_TH;
    v_nxt = stuck || spike ? V_RESET : vs;
    refrac_nxt = stuck ? refrac - RW'(1) : spike ? RW'(REFRAC_STEPS) : '0;
  end
endmodule

// File: rtl/lif_neuron_array.sv
// lif_neuron_array: N time-multiplexed LIF neurons; beats accumulate in IDLE, a tick sweeps
// every neuron in index order through one shared update core.
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int N_NEURONS = 8,
  parameter int DATA_W = 16,
  parameter logic signed [DATA_W-1:0] V_REST = 0,
  parameter logic signed [DATA_W-1:0] V_TH = 1024,
  parameter logic signed [DATA_W-1:0] V_RESET = 0,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC_STEPS = 4,
  localparam int IDX_W = $clog2(N_NEURONS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IDX_W-1:0]         in_idx,
  input  logic signed [DATA_W-1:0] in_current,
  input  logic                     tick_valid,
  output logic                     tick_ready,
  output logic                     spike_valid,
  output logic [IDX_W-1:0]         spike_idx,
  output logic                     v_valid,
  output logic [IDX_W-1:0]         v_idx,
  output logic signed [DATA_W-1:0] v_out,
  output logic                     step_done
);
  localparam int RW = refrac_w(REFRAC_STEPS);
  localparam logic [IDX_W:0] N_L = (IDX_W + 1)'(N_NEURONS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_NEURONS - 1);
  state_t state;
  logic [IDX_W-1:0] cnt;
  logic signed [DATA_W-1:0] v_mem [N_NEURONS];
  logic signed [DATA_W-1:0] i_acc [N_NEURONS];
  logic [RW-1:0] refrac [N_NEURONS];
  logic signed [DATA_W-1:0] v_nxt;
  logic [RW-1:0] refrac_nxt;
  logic spike;
  assign in_ready = state == IDLE;
  assign tick_ready = state == IDLE;
  lif_update_core #(
    .DATA_W(DATA_W), .V_REST(V_REST), .V_TH(V_TH), .V_RESET(V_RESET),
    .LEAK_SHIFT(LEAK_SHIFT), .REFRAC_STEPS(REFRAC_STEPS), .RW(RW)
  ) u_core (
    .v(v_mem[cnt]), .i_acc(i_acc[cnt]), .refrac(refrac[cnt]),
    .v_nxt(v_nxt), .refrac_nxt(refrac_nxt), .spike(spike)
  );
  // Out-of-range beats still handshake but leave every accumulator untouched.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      spike_valid <= 1'b0;
      spike_idx <= '0;
      v_valid <= 1'b0;
      v_idx <= '0;
      v_out <= '0;
      step_done <= 1'b0;
      for (int n = 0; n < N_NEURONS; n++) begin
        v_mem[n] <= V_REST;
        i_acc[n] <= '0;
        refrac[n] <= '0;
      end
    end else if (state == IDLE) begin
      spike_valid <= 1'b0;
      v_valid <= 1'b0;
      step_done <= 1'b0;
      if (in_valid && {1'b0, in_idx} < N_L)
        i_acc[in_idx] <= DATA_W'(sat_add(64'(i_acc[in_idx]), 64'(in_current), DATA_W));
      if (tick_valid) begin
        state <= SWEEP;
        cnt <= '0;
      end
    end else begin
      v_mem[cnt] <= v_nxt;
      i_acc[cnt] <= '0;
      refrac[cnt] <= refrac_nxt;
      spike_valid <= spike;
      spike_idx <= cnt;
      v_valid <= 1'b1;
      v_idx <= cnt;
      v_out <= v_nxt;
      step_done <= cnt == LAST;
      cnt <= cnt + IDX_W'(1);
      if (cnt == LAST) state <= IDLE;
    end
endmodule
